// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered load.
// New values are staged in a pending register and swapped in only at a frame boundary.
module seg7_scan_ctrl #(
   parameter int P_DIV = 4
) (
   input  logic        i_w_clk,
   input  logic        i_w_reset,
   input  logic        i_w_load,
   input  logic [15:0] i_w_data,
   input  logic        i_w_lzb,
   output logic        o_w_ready,
   output logic [3:0]  o_w_an,
   output logic [6:0]  o_w_7seg
);

   localparam logic       ST_BLANK  = 1'b0;
   localparam logic       ST_SCAN   = 1'b1;
   localparam logic [15:0] DIV_LAST = 16'(P_DIV - 1);

   logic        state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;

   logic        tick;
   logic        boundary;
   logic        accept;
   logic [3:0]  nibble;
   logic        blank_digit;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign tick      = (state_q == ST_SCAN) && (presc_q == DIV_LAST);
   assign boundary  = tick && (idx_q == 2'd3);
   assign o_w_ready = ~pend_vld_q;
   assign accept    = i_w_load && o_w_ready;

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      idx_d      = idx_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (state_q == ST_BLANK) begin
         presc_d    = 16'd0;
         idx_d      = 2'd0;
         pend_vld_d = 1'b0;
         if (i_w_load) begin
            disp_d  = i_w_data;
            state_d = ST_SCAN;
         end
      end else begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
         idx_d   = tick ? idx_q + 2'd1 : idx_q;
         // A swap at the boundary blocks capture (ready is low), so a load
         // landing on a boundary with pending empty waits for the next frame.
         if (boundary && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
         end else if (accept) begin
            pend_d     = i_w_data;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         state_q    <= ST_BLANK;
         presc_q    <= 16'd0;
         idx_q      <= 2'd0;
         disp_q     <= 16'd0;
         pend_q     <= 16'd0;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   always_comb begin
      nibble      = 4'h0;
      blank_digit = 1'b0;
      case (idx_q)
         2'd0: nibble = disp_q[3:0];
         2'd1: begin
            nibble      = disp_q[7:4];
            blank_digit = i_w_lzb && (disp_q[15:4] == 12'd0);
         end
         2'd2: begin
            nibble      = disp_q[11:8];
            blank_digit = i_w_lzb && (disp_q[15:8] == 8'd0);
         end
         default: begin
            nibble      = disp_q[15:12];
            blank_digit = i_w_lzb && (disp_q[15:12] == 4'd0);
         end
      endcase
   end

   always_comb begin
      o_w_an   = 4'hF;
      o_w_7seg = 7'h00;
      if ((state_q == ST_SCAN) && !blank_digit) begin
         o_w_an   = ~(4'b0001 << idx_q);
         o_w_7seg = seg_decode(nibble);
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed vector bench for seg7_scan_ctrl at P_DIV=4 (16-cycle frames).
// Each record gives the inputs held across one rising edge and the outputs expected just after it.
module tb_seg7_scan_ctrl;

   typedef struct {
      logic        rst;
      logic        load;
      logic [15:0] data;
      logic        lzb;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        rdy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data = 16'h0;
   logic        lzb = 1'b0;
   logic        ready;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int fails  = 0;

   vec_t vecs[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg7_scan_ctrl #(.P_DIV(4)) dut (
      .i_w_clk   (clk),
      .i_w_reset (rst),
      .i_w_load  (load),
      .i_w_data  (data),
      .i_w_lzb   (lzb),
      .o_w_ready (ready),
      .o_w_an    (an),
      .o_w_7seg  (seg)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic l, input logic [15:0] d, input logic z,
                      input logic [3:0] a, input logic [6:0] s, input logic y);
      vec_t v;
      v.rst = r; v.load = l; v.data = d; v.lzb = z; v.an = a; v.seg = s; v.rdy = y;
      vecs.push_back(v);
   endtask

   // Idle cycles of an unblanked scan of value v at frame positions p0..p0+n-1.
   task automatic scan(input logic [15:0] v, input int n, input int p0, input logic y);
      for (int i = 0; i < n; i++) begin
         int d;
         logic [3:0] nib;
         d   = ((p0 + i) % 16) / 4;
         nib = 4'((v >> (4 * d)) & 16'hF);
         add(1'b0, 1'b0, 16'h0, 1'b0, ~(4'b0001 << d), seg_tab[nib], y);
      end
   endtask

   // Blanked scan at positions p0..p1; nonzero-digit slot d1 shows s1, digit0 shows 3F.
   task automatic lzb_scan(input int p0, input int p1, input logic d1_on, input logic [6:0] s1,
                           input logic y);
      for (int p = p0; p <= p1; p++) begin
         if (p < 4)                 add(1'b0, 1'b0, 16'h0, 1'b1, 4'hE, 7'h3F, y);
         else if (p < 8 && d1_on)   add(1'b0, 1'b0, 16'h0, 1'b1, 4'hD, s1, y);
         else                       add(1'b0, 1'b0, 16'h0, 1'b1, 4'hF, 7'h00, y);
      end
   endtask

   initial begin
      // reset and idle BLANK
      add(1, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      add(1, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      add(0, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      add(0, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      // load 1234 from BLANK, full frame plus part of the next
      add(0, 1, 16'h1234, 0, 4'hE, 7'h66, 1);
      scan(16'h1234, 15, 1, 1);
      scan(16'h1234, 6, 0, 1);
      // staged load, then an ignored load while pending is full
      add(0, 1, 16'h5678, 0, 4'hD, 7'h4F, 0);
      add(0, 1, 16'h9999, 0, 4'hD, 7'h4F, 0);
      scan(16'h1234, 8, 8, 0);
      scan(16'h5678, 16, 0, 1);
      // load on a boundary cycle waits a whole frame
      add(0, 1, 16'hABCD, 0, 4'hE, 7'h7F, 0);
      scan(16'h5678, 15, 1, 0);
      scan(16'hABCD, 5, 0, 1);
      // mid-frame reset discards pending 1111
      add(0, 1, 16'h1111, 0, 4'hD, 7'h39, 0);
      add(1, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      for (int i = 0; i < 20; i++) add(0, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      // reset beats load in the same cycle
      add(1, 1, 16'h2222, 0, 4'hF, 7'h00, 1);
      add(0, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      add(0, 0, 16'h0, 0, 4'hF, 7'h00, 1);
      // leading-zero blanking: 0050, then 0000 staged on a boundary
      add(0, 1, 16'h0050, 1, 4'hE, 7'h3F, 1);
      lzb_scan(1, 15, 1'b1, 7'h6D, 1'b1);
      add(0, 1, 16'h0000, 1, 4'hE, 7'h3F, 0);
      lzb_scan(1, 15, 1'b1, 7'h6D, 1'b0);
      lzb_scan(0, 15, 1'b0, 7'h00, 1'b1);
      // blanking off again: zeros now visible on every digit
      for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 0, 4'hE, 7'h3F, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 0, 4'hD, 7'h3F, 1);
      add(0, 0, 16'h0, 0, 4'hB, 7'h3F, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst  = vecs[i].rst;
         load = vecs[i].load;
         data = vecs[i].data;
         lzb  = vecs[i].lzb;
         @(posedge clk);
         #1;
         checks++;
         if (an !== vecs[i].an) begin
            fails++;
            $display("FAIL vec%0d an: got %h expected %h", i, an, vecs[i].an);
         end
         checks++;
         if (seg !== vecs[i].seg) begin
            fails++;
            $display("FAIL vec%0d seg: got %h expected %h", i, seg, vecs[i].seg);
         end
         checks++;
         if (ready !== vecs[i].rdy) begin
            fails++;
            $display("FAIL vec%0d ready: got %b expected %b", i, ready, vecs[i].rdy);
         end
      end
      rst  = 1'b0;
      load = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter P_DIV, default 4, SHALL set the clock cycles each digit is displayed (legal range 2..65535).
REQ-002 i_w_clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 i_w_reset  input  1  synchronous, active-high reset.
REQ-004 i_w_load  input  1  load request for a new 4-digit value; accepted only when o_w_ready=1.
REQ-005 i_w_data  input  16  four hex digits; [3:0]=digit0 (least significant) ... [15:12]=digit3.
REQ-006 i_w_lzb  input  1  leading-zero blanking enable, sampled every cycle.
REQ-007 o_w_ready  output  1  high when a load can be accepted.
REQ-008 o_w_an  output  4  active-low digit enables; bit k drives digit k.
REQ-009 o_w_7seg  output  7  active-high segments, bit0=a ... bit6=g.

Function
REQ-010 Registered state SHALL be: state {BLANK, SCAN}, prescaler counter, 2-bit digit index, 16-bit display register, 16-bit pending register, and a pending-valid flag.
REQ-011 Outputs SHALL be decoded combinationally from registered state, with no added latency.
REQ-012 In BLANK: o_w_an=4'hF, o_w_7seg=7'h00, counters held at 0, o_w_ready=1.
REQ-013 In BLANK, a load (i_w_load=1) SHALL, on the next cycle, write i_w_data into the display register, enter SCAN with digit index 0 and prescaler 0, and leave pending empty.
REQ-014 In SCAN, the prescaler SHALL count 0..P_DIV-1 and wrap; the tick is the cycle where it equals P_DIV-1.
REQ-015 On a tick, the digit index SHALL advance 0->1->2->3->0; one frame is 4*P_DIV cycles.
REQ-016 The frame boundary is a tick while the digit index is 3.
REQ-017 In SCAN, o_w_an SHALL drive the indexed bit low and the others high; o_w_7seg SHALL encode the indexed nibble of the display register.
REQ-018 Segment codes 0..F SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-019 In SCAN, a load with o_w_ready=1 SHALL capture i_w_data into pending and set pending-valid; o_w_ready SHALL be ~pending-valid.
REQ-020 A load while o_w_ready=0 SHALL be ignored, leaving pending unchanged.
REQ-021 At a frame boundary with pending-valid=1, the display register SHALL take pending and pending-valid SHALL clear; digit0 of the new value shows from the next cycle.
REQ-022 A load arriving on a boundary cycle with pending empty SHALL be captured into pending and applied at the following boundary, not the current one.
REQ-023 With i_w_lzb=1, digit k (k=3..1) SHALL be blanked (o_w_an=4'hF, o_w_7seg=7'h00 during its slot) when its nibble and all more-significant nibbles are 0.
REQ-024 Digit0 SHALL never be blanked; the scan timing SHALL be unaffected by blanking.

Reset
REQ-025 While i_w_reset=1 at a clock edge, the block SHALL enter BLANK, zero all counters, the display register and the pending register, and clear pending-valid.
REQ-026 After reset: o_w_an=4'hF, o_w_7seg=7'h00, o_w_ready=1.
REQ-027 Reset SHALL take priority over i_w_load in the same cycle, and mid-frame reset SHALL discard any pending value.

Verification (P_DIV=4)
REQ-028 Reset held 2 cycles, then released -> o_w_an=F, o_w_7seg=00, o_w_ready=1 until a load.
REQ-029 Load 16'h1234 in BLANK -> next cycle an=1110 seg=66; 4 cycles later an=1101 seg=4F; then 1011/5B; then 0111/06; repeats every 16 cycles.
REQ-030 Load 16'h5678 at cycle 5 of a frame -> o_w_ready=0 next cycle; 1234 display continues to the boundary; next cycle an=1110 seg=7F; o_w_ready=1.
REQ-031 Second load 16'h9999 while o_w_ready=0 -> ignored; the display later shows 5678, never 9999.
REQ-032 i_w_lzb=1, data 16'h0050 -> digit3 and digit2 slots an=F seg=00; digit1 seg=6D; digit0 seg=3F. With data 16'h0000, only the digit0 slot is active (seg=3F).
REQ-033 Reset asserted mid-frame with pending valid -> next cycle BLANK outputs, o_w_ready=1; the old pending value is never displayed.
